// File: rtl/carfield_apb_map_pkg.sv
// Carfield peripheral APB segment address map.
// Shared between the demultiplexer and its address decoder.
package carfield_apb_map_pkg;

    localparam int NumApbSub = 8;

    // Downstream completer indices; value equals the sub_psel_o bit position.
    typedef enum logic [2:0] {
        ApbCan         = 3'd0,
        ApbTimer       = 3'd1,
        ApbAdvTimer    = 3'd2,
        ApbWatchdog    = 3'd3,
        ApbHyperbus    = 3'd4,
        ApbStreamerCfg = 3'd5,
        ApbStreamerApb = 3'd6,
        ApbSpw         = 3'd7
    } apb_idx_e;

    // One region of the map: start_addr inclusive, end_addr exclusive.
    typedef struct packed {
        apb_idx_e    idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    localparam addr_rule_t ApbAddrMap [NumApbSub] = '{
        '{idx: ApbCan,         start_addr: 32'h2000_1000, end_addr: 32'h2000_2000},
        '{idx: ApbTimer,       start_addr: 32'h2000_4000, end_addr: 32'h2000_5000},
        '{idx: ApbAdvTimer,    start_addr: 32'h2000_5000, end_addr: 32'h2000_6000},
        '{idx: ApbWatchdog,    start_addr: 32'h2000_7000, end_addr: 32'h2000_8000},
        '{idx: ApbHyperbus,    start_addr: 32'h2000_8000, end_addr: 32'h2000_9000},
        '{idx: ApbStreamerCfg, start_addr: 32'h2000_9000, end_addr: 32'h2001_1000},
        '{idx: ApbStreamerApb, start_addr: 32'h2001_1000, end_addr: 32'h2001_9000},
        '{idx: ApbSpw,         start_addr: 32'h2001_9000, end_addr: 32'h2001_A000}
    };

    // Read data returned for unmapped, disabled or timed-out accesses.
    localparam logic [31:0] ApbErrData = 32'hBADC_AB1E;

endpackage

// File: rtl/carfield_apb_addr_decode.sv
// Combinational address decoder for the Carfield peripheral APB segment.
// Disabled regions decode as holes (hit = 0).
module carfield_apb_addr_decode
    import carfield_apb_map_pkg::*;
#(
    parameter bit CanEnable       = 1'b1,
    parameter bit StreamerEnable  = 1'b1,
    parameter bit SpaceWireEnable = 1'b1
) (
    input  logic [31:0] addr,
    output logic        hit,
    output apb_idx_e    idx
);

    function automatic logic region_enabled(input apb_idx_e i);
        case (i)
            ApbCan:                         return CanEnable;
            ApbStreamerCfg, ApbStreamerApb: return StreamerEnable;
            ApbSpw:                         return SpaceWireEnable;
            default:                        return 1'b1;
        endcase
    endfunction

    // Range-match the address against every enabled region of the map.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit = 1'b0;
        idx = ApbCan;
        for (int i = 0; i < NumApbSub; i++) begin
            if (region_enabled(ApbAddrMap[i].idx) &&
                addr >= ApbAddrMap[i].start_addr && addr < ApbAddrMap[i].end_addr) begin
                hit = 1'b1;
                idx = ApbAddrMap[i].idx;
            end
        end
    end

endmodule

// File: rtl/carfield_apb_periph_demux.sv
// Registered APB demultiplexer and error responder for the Carfield
// peripheral segment. One transfer outstanding at a time.
// Optional access-phase timeout: define CARFIELD_APB_DEMUX_TIMEOUT_EN.
module carfield_apb_periph_demux
    import carfield_apb_map_pkg::*;
#(
    parameter bit          CanEnable       = 1'b1,
    parameter bit          StreamerEnable  = 1'b1,
    parameter bit          SpaceWireEnable = 1'b1,
    parameter int unsigned TimeoutCycles   = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic                        pwrite_i,
    input  logic [31:0]                 paddr_i,
    input  logic [31:0]                 pwdata_i,
    input  logic [3:0]                  pstrb_i,
    input  logic [2:0]                  pprot_i,
    output logic                        pready_o,
    output logic [31:0]                 prdata_o,
    output logic                        pslverr_o,
    output logic [NumApbSub-1:0]        sub_psel_o,
    output logic                        sub_penable_o,
    output logic                        sub_pwrite_o,
    output logic [31:0]                 sub_paddr_o,
    output logic [31:0]                 sub_pwdata_o,
    output logic [3:0]                  sub_pstrb_o,
    output logic [2:0]                  sub_pprot_o,
    input  logic [NumApbSub-1:0]        sub_pready_i,
    input  logic [NumApbSub-1:0][31:0]  sub_prdata_i,
    input  logic [NumApbSub-1:0]        sub_pslverr_i,
    output logic                        timeout_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;

    logic [1:0]  state_q;
    apb_idx_e    idx_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        drop_q;    // upstream abandoned the transfer; swallow the response
    logic        timeout_q;
    logic        timeout_hit;
    logic        dec_hit;
    apb_idx_e    dec_idx;

    carfield_apb_addr_decode #(
        .CanEnable       (CanEnable),
        .StreamerEnable  (StreamerEnable),
        .SpaceWireEnable (SpaceWireEnable)
    ) i_addr_decode (
        .addr (paddr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

`ifdef CARFIELD_APB_DEMUX_TIMEOUT_EN
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q;

    // Count ACCESS cycles without ready; cleared while entering ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == StSetup) begin
            cnt_q <= '0;
        end else if (state_q == StAccess && !sub_pready_i[idx_q]) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The last waiting cycle aborts; a completer ready in that cycle wins.
    assign timeout_hit = (state_q == StAccess) && !sub_pready_i[idx_q] && (cnt_q == TimeoutLast);
`else
    // Without the timeout feature ACCESS waits indefinitely.
    logic [CntW-1:0] unused_timeout_cnt;
    assign unused_timeout_cnt = '0;
    assign timeout_hit        = 1'b0;
`endif

    // Transfer FSM: accept, decode, run the downstream transfer, respond.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            idx_q        <= ApbCan;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
            timeout_q    <= 1'b0;
            sub_pwrite_o <= 1'b0;
            sub_paddr_o  <= '0;
            sub_pwdata_o <= '0;
            sub_pstrb_o  <= '0;
            sub_pprot_o  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (psel_i && !penable_i) begin
                        drop_q <= 1'b0;
                        if (dec_hit) begin
                            idx_q        <= dec_idx;
                            sub_pwrite_o <= pwrite_i;
                            sub_paddr_o  <= paddr_i;
                            sub_pwdata_o <= pwdata_i;
                            sub_pstrb_o  <= pstrb_i;
                            sub_pprot_o  <= pprot_i;
                            state_q      <= StSetup;
                        end else begin
                            rdata_q <= ApbErrData;
                            err_q   <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StSetup: begin
                    if (!psel_i) drop_q <= 1'b1;
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (!psel_i) drop_q <= 1'b1;
                    if (sub_pready_i[idx_q]) begin
                        rdata_q <= sub_prdata_i[idx_q];
                        err_q   <= sub_pslverr_i[idx_q];
                        state_q <= StResp;
                    end else if (timeout_hit) begin
                        rdata_q   <= ApbErrData;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Downstream select and upstream response derived from the registered state.
    always_comb begin
        sub_psel_o = '0;
        if (state_q == StSetup || state_q == StAccess) sub_psel_o[idx_q] = 1'b1;
        sub_penable_o = (state_q == StAccess);
        pready_o      = (state_q == StResp) && !drop_q;
        prdata_o      = pready_o ? rdata_q : '0;
        pslverr_o     = pready_o && err_q;
    end

    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_carfield_apb_periph_demux.sv
// Directed self-checking bench for carfield_apb_periph_demux.
// A second instance with CanEnable=0 shares the stimulus.
module tb_carfield_apb_periph_demux;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              psel_i, penable_i, pwrite_i;
    logic [31:0]       paddr_i, pwdata_i;
    logic [3:0]        pstrb_i;
    logic [2:0]        pprot_i;
    logic              pready_o, pslverr_o, sub_penable_o, sub_pwrite_o, timeout_o;
    logic [31:0]       prdata_o, sub_paddr_o, sub_pwdata_o;
    logic [7:0]        sub_psel_o;
    logic [3:0]        sub_pstrb_o;
    logic [2:0]        sub_pprot_o;
    logic [7:0]        sub_pready_i, sub_pslverr_i;
    logic [7:0][31:0]  sub_prdata_i;

    logic              nc_pready, nc_pslverr, nc_penable, nc_pwrite, nc_timeout;
    logic [31:0]       nc_prdata, nc_paddr, nc_pwdata;
    logic [7:0]        nc_psel;
    logic [3:0]        nc_pstrb;
    logic [2:0]        nc_pprot;

    int n_checks = 0;
    int n_errors = 0;

    // Per-transfer observations filled by xfer().
    int          r_cyc, r_sel_cycles, r_tmo, nc_cyc;
    logic [31:0] r_data, nc_data;
    logic        r_err, r_fwd_ok, nc_err;
    logic [7:0]  r_sel_or, nc_sel_or;

    always #5 clk_i = ~clk_i;

    carfield_apb_periph_demux #(.TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .pprot_i(pprot_i),
        .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
        .sub_psel_o(sub_psel_o), .sub_penable_o(sub_penable_o), .sub_pwrite_o(sub_pwrite_o),
        .sub_paddr_o(sub_paddr_o), .sub_pwdata_o(sub_pwdata_o), .sub_pstrb_o(sub_pstrb_o),
        .sub_pprot_o(sub_pprot_o), .sub_pready_i(sub_pready_i), .sub_prdata_i(sub_prdata_i),
        .sub_pslverr_i(sub_pslverr_i), .timeout_o(timeout_o)
    );

    carfield_apb_periph_demux #(.CanEnable(1'b0), .TimeoutCycles(16)) dut_nocan (
        .clk_i(clk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .pprot_i(pprot_i),
        .pready_o(nc_pready), .prdata_o(nc_prdata), .pslverr_o(nc_pslverr),
        .sub_psel_o(nc_psel), .sub_penable_o(nc_penable), .sub_pwrite_o(nc_pwrite),
        .sub_paddr_o(nc_paddr), .sub_pwdata_o(nc_pwdata), .sub_pstrb_o(nc_pstrb),
        .sub_pprot_o(nc_pprot), .sub_pready_i(sub_pready_i), .sub_prdata_i(sub_prdata_i),
        .sub_pslverr_i(sub_pslverr_i), .timeout_o(nc_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One upstream transfer; the completer at idx answers after 'waits' ACCESS cycles.
    // r_cyc counts cycles after the setup edge (-1 if budget expires).
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int waits, input int budget, input logic [31:0] rdata,
                        input logic rerr, input logic [2:0] idx);
        int acc = 0;
        for (int k = 0; k < 8; k++) sub_prdata_i[k] = 32'hDEAD_0000 | 32'(k);
        sub_prdata_i[idx]  = rdata;
        sub_pslverr_i      = '0;
        sub_pslverr_i[idx] = rerr;
        sub_pready_i       = '0;
        r_cyc = -1; r_data = '0; r_err = 1'b0; r_sel_or = '0; r_sel_cycles = 0;
        r_fwd_ok = 1'b1; r_tmo = 0; nc_cyc = -1; nc_data = '0; nc_err = 1'b0; nc_sel_or = '0;
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr;
        pwdata_i = wdata; pstrb_i = 4'hF; pprot_i = 3'b010;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk_i);
            nc_sel_or |= nc_psel;
            if (nc_pready && nc_cyc < 0) begin
                nc_cyc = c; nc_data = nc_prdata; nc_err = nc_pslverr;
            end
            if (sub_psel_o != 8'h00) begin
                r_sel_cycles++;
                r_sel_or |= sub_psel_o;
                if (sub_paddr_o != addr || sub_pwrite_o != wr || sub_pstrb_o != 4'hF ||
                    sub_pprot_o != 3'b010 || (wr && sub_pwdata_o != wdata))
                    r_fwd_ok = 1'b0;
            end
            if (timeout_o) r_tmo++;
            if (pready_o) begin
                r_cyc = c; r_data = prdata_o; r_err = pslverr_o;
                break;
            end
            if (sub_penable_o) begin
                if (acc >= waits) sub_pready_i[idx] = 1'b1;
                acc++;
            end else begin
                sub_pready_i = '0;
            end
        end
        sub_pready_i = '0;
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    initial begin
        int sel_seen, rdy_seen, acc;
        rst_i = 1'b1; psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0;
        pwdata_i = '0; pstrb_i = '0; pprot_i = '0;
        sub_pready_i = '0; sub_pslverr_i = '0; sub_prdata_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_psel", {24'd0, sub_psel_o}, 32'h0);
        check("reset_ctrl", {27'd0, pready_o, pslverr_o, sub_penable_o, sub_pwrite_o, timeout_o}, 32'h0);
        check("reset_prdata", prdata_o, 32'h0);
        check("reset_paddr", sub_paddr_o, 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Timer read, zero wait.
        xfer(32'h2000_4004, 1'b0, 32'h0, 0, 50, 32'h1234_5678, 1'b0, 3'd1);
        check("timer_cyc", 32'(r_cyc), 32'd3);
        check("timer_data", r_data, 32'h1234_5678);
        check("timer_err", {31'd0, r_err}, 32'h0);
        check("timer_sel", {24'd0, r_sel_or}, 32'h02);
        check("timer_fwd", {31'd0, r_fwd_ok}, 32'h1);

        // Streamer APB write with five wait states.
        xfer(32'h2001_1FFC, 1'b1, 32'hA5A5_0FF0, 5, 50, 32'h0, 1'b0, 3'd6);
        check("strm_cyc", 32'(r_cyc), 32'd8);
        check("strm_sel_cycles", 32'(r_sel_cycles), 32'd7);
        check("strm_sel", {24'd0, r_sel_or}, 32'h40);
        check("strm_fwd", {31'd0, r_fwd_ok}, 32'h1);
        check("strm_err", {31'd0, r_err}, 32'h0);

        // Hole between CAN and timer.
        xfer(32'h2000_2000, 1'b0, 32'h0, 0, 50, 32'h0, 1'b0, 3'd0);
        check("hole_cyc", 32'(r_cyc), 32'd1);
        check("hole_data", r_data, 32'hBADC_AB1E);
        check("hole_err", {31'd0, r_err}, 32'h1);
        check("hole_sel", {24'd0, r_sel_or}, 32'h0);

        // CAN read: hit on the default build, hole with CanEnable=0.
        xfer(32'h2000_1000, 1'b0, 32'h0, 0, 50, 32'h0000_0CA1, 1'b0, 3'd0);
        check("can_cyc", 32'(r_cyc), 32'd3);
        check("can_data", r_data, 32'h0000_0CA1);
        check("can_sel", {24'd0, r_sel_or}, 32'h01);
        check("nocan_cyc", 32'(nc_cyc), 32'd1);
        check("nocan_data", nc_data, 32'hBADC_AB1E);
        check("nocan_err", {31'd0, nc_err}, 32'h1);
        check("nocan_sel", {24'd0, nc_sel_or}, 32'h0);

        // Boundaries around the two streamer regions and the top of the segment.
        xfer(32'h2001_0FFF, 1'b0, 32'h0, 0, 50, 32'h5555_0005, 1'b0, 3'd5);
        check("bnd_0fff_sel", {24'd0, r_sel_or}, 32'h20);
        check("bnd_0fff_data", r_data, 32'h5555_0005);
        xfer(32'h2001_1000, 1'b0, 32'h0, 0, 50, 32'h6666_0006, 1'b0, 3'd6);
        check("bnd_1000_sel", {24'd0, r_sel_or}, 32'h40);
        check("bnd_1000_data", r_data, 32'h6666_0006);
        xfer(32'h2001_A000, 1'b0, 32'h0, 0, 50, 32'h0, 1'b0, 3'd7);
        check("bnd_a000_cyc", 32'(r_cyc), 32'd1);
        check("bnd_a000_err", {31'd0, r_err}, 32'h1);
        check("bnd_a000_sel", {24'd0, r_sel_or}, 32'h0);

        // Completer error passes through (hyperbus write, one wait).
        xfer(32'h2000_8010, 1'b1, 32'h0BAD_F00D, 1, 50, 32'h7777_7777, 1'b1, 3'd4);
        check("hyp_cyc", 32'(r_cyc), 32'd4);
        check("hyp_err", {31'd0, r_err}, 32'h1);
        check("hyp_data", r_data, 32'h7777_7777);

        // Upstream drops psel in SETUP: downstream completes, no upstream ready.
        sub_pslverr_i = '0;
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h2000_4000; pwrite_i = 1'b0;
        @(posedge clk_i); #1;
        psel_i = 1'b0;
        sel_seen = 0; rdy_seen = 0; acc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (sub_psel_o[1]) sel_seen++;
            if (pready_o) rdy_seen++;
            if (sub_penable_o) begin
                if (acc >= 1) sub_pready_i[1] = 1'b1;
                acc++;
            end else begin
                sub_pready_i = '0;
            end
        end
        sub_pready_i = '0;
        check("drop_sel_cycles", 32'(sel_seen), 32'd3);
        check("drop_no_ready", 32'(rdy_seen), 32'd0);

        // Watchdog never ready.
`ifdef CARFIELD_APB_DEMUX_TIMEOUT_EN
        xfer(32'h2000_7000, 1'b0, 32'h0, 100000, 40, 32'h0, 1'b0, 3'd3);
        check("tmo_cyc", 32'(r_cyc), 32'd18);
        check("tmo_pulse", 32'(r_tmo), 32'd1);
        check("tmo_err", {31'd0, r_err}, 32'h1);
        check("tmo_data", r_data, 32'hBADC_AB1E);
        @(negedge clk_i);
        check("tmo_sel_cleared", {24'd0, sub_psel_o}, 32'h0);
`else
        xfer(32'h2000_7000, 1'b0, 32'h0, 100000, 1000, 32'h0, 1'b0, 3'd3);
        check("wait_no_ready", 32'(r_cyc), 32'hFFFF_FFFF);
        check("wait_no_tmo", 32'(r_tmo), 32'd0);
        @(negedge clk_i);
        check("wait_sel_held", {24'd0, sub_psel_o}, 32'h08);
`endif

        // Reset while in ACCESS.
        xfer(32'h2000_7000, 1'b0, 32'h0, 100000, 10, 32'h0, 1'b0, 3'd3);
        @(negedge clk_i);
        check("pre_rst_access", {31'd0, sub_penable_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_sel", {24'd0, sub_psel_o}, 32'h0);
        check("rst_mid_ctrl", {27'd0, pready_o, pslverr_o, sub_penable_o, sub_pwrite_o, timeout_o}, 32'h0);
        check("rst_mid_addr", sub_paddr_o, 32'h0);
        check("rst_mid_prdata", prdata_o, 32'h0);
        @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;

        // SpaceWire read after reset.
        xfer(32'h2001_9000, 1'b0, 32'h0, 0, 50, 32'hCAFE_F00D, 1'b0, 3'd7);
        check("spw_cyc", 32'(r_cyc), 32'd3);
        check("spw_data", r_data, 32'hCAFE_F00D);
        check("spw_sel", {24'd0, r_sel_or}, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/carfield_apb_periph_demux.md
# carfield_apb_periph_demux

Registered APB demultiplexer and error responder for the Carfield peripheral APB segment (0x2000_1000–0x2001_9FFF). Sits behind the host AXI-to-APB bridge. Decodes each upstream transfer against the fixed peripheral address map and forwards it to one of eight downstream APB completers. Unmapped or disabled regions get a deterministic error response.

## Interface
Parameters:
- CanEnable, 1, CAN region decodes; 0 → region treated as hole
- StreamerEnable, 1, both streamer regions decode; 0 → holes
- SpaceWireEnable, 1, SpaceWire region decodes; 0 → hole
- TimeoutCycles, 256, access-phase cycles before abort (≥2; used only with timeout feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- psel_i, penable_i, pwrite_i  in  1  upstream APB control
- paddr_i  in  32  upstream address
- pwdata_i  in  32  write data; pstrb_i in 4; pprot_i in 3
- pready_o  out  1  upstream ready
- prdata_o  out  32  upstream read data
- pslverr_o  out  1  upstream error
- sub_psel_o  out  8  one-hot downstream select; index from the map package
- sub_penable_o, sub_pwrite_o  out  1  shared downstream control
- sub_paddr_o  out  32; sub_pwdata_o out 32; sub_pstrb_o out 4; sub_pprot_o out 3  shared, registered
- sub_pready_i  in  8; sub_prdata_i in 8×32; sub_pslverr_i in 8  per-completer response
- timeout_o  out  1  one-cycle pulse on a timeout abort

## Operation
- Map (index, base, size): 0 CAN 0x2000_1000/0x1000; 1 timer 0x2000_4000/0x1000; 2 adv-timer 0x2000_5000/0x1000; 3 watchdog 0x2000_7000/0x1000; 4 hyperbus cfg 0x2000_8000/0x1000; 5 streamer cfg 0x2000_9000/0x8000; 6 streamer apb 0x2001_1000/0x8000; 7 SpaceWire 0x2001_9000/0x1000.
- Hit rule: base ≤ paddr < base+size, unsigned 32-bit. Everything else is a miss, including 0x2000_2000–0x2000_3FFF, 0x2000_6000–0x2000_6FFF, and disabled regions.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on psel_i && !penable_i, latch addr, wdata, strb, prot and write. Decode the latched address. Hit → SETUP with index latched. Miss → RESP with error flag set.
- SETUP: sub_psel_o[idx]=1, sub_penable_o=0. Next state is ACCESS.
- ACCESS: sub_psel_o[idx]=1, sub_penable_o=1. On sub_pready_i[idx], capture prdata and pslverr from that index, then go to RESP.
- RESP: pready_o=1 for exactly one cycle, with the captured prdata_o/pslverr_o. Then IDLE.
- Miss response: prdata_o=0xBADC_AB1E, pslverr_o=1. Writes on a miss have no side effect.
- Outside RESP: pready_o=0, prdata_o=0, pslverr_o=0.
- Upstream psel_i drops before RESP (protocol violation): the downstream transfer completes normally, the response is discarded, and the FSM returns to IDLE.
- Only one transfer is outstanding at a time. New setups are ignored until the FSM is back in IDLE.

## Timing
- Reset: FSM=IDLE. All outputs 0, including sub_psel_o=8'h00 and timeout_o=0.
- Reset mid-transfer: immediate return to IDLE; downstream psel drops asynchronously.
- Hit with zero-wait completer: upstream setup at cycle 0, SETUP at 1, ACCESS at 2, pready_o at 3. That is 3 cycles to ready, plus one per completer wait state.
- Miss: setup at cycle 0, pready_o at cycle 1.
- Downstream address and data are stable from SETUP through the end of ACCESS.
- Back-to-back transfers: the next upstream setup is accepted in the cycle after RESP.

## Configuration
- Macro: CARFIELD_APB_DEMUX_TIMEOUT_EN.
- Defined: a counter (clog2(TimeoutCycles)+1 bits) clears on ACCESS entry and increments each ACCESS cycle without sub_pready_i[idx].
  - When the count reaches TimeoutCycles, the access aborts: sub_psel_o goes to 0 the next cycle, timeout_o pulses, and RESP returns prdata_o=0xBADC_AB1E, pslverr_o=1.
  - If sub_pready_i arrives in the same cycle as the limit, the completer response wins.
- Undefined: no counter. ACCESS waits indefinitely and timeout_o is tied to 0.

## Structure
- Shared package carfield_apb_map_pkg holds:
  - NumApbSub=8 and the index enum (ApbCan…ApbSpw);
  - the addr_rule_t struct {idx, start, end} and the localparam rule array;
  - ApbErrData=32'hBADC_AB1E.
- One combinational sub-module, carfield_apb_addr_decode. It takes the address plus the enable parameters and outputs hit and idx.

## Test plan
- Read 0x2000_4004, timer returns 0x1234_5678 with zero wait → pready_o at cycle 3, prdata_o=0x1234_5678, pslverr_o=0, only sub_psel_o[1] ever high.
- Write 0x2001_1FFC with streamer holding pready low 5 cycles → sub_psel_o[6] high 7 cycles, pwdata forwarded, pready_o 1 cycle after sub_pready_i.
- Read 0x2000_2000 (hole), and 0x2000_1000 with CanEnable=0 → pready_o at cycle 1, prdata_o=0xBADC_AB1E, pslverr_o=1, sub_psel_o stays 0.
- Timeout build, TimeoutCycles=16, watchdog never ready → timeout_o pulse, pslverr_o=1, sub_psel_o cleared. Without the macro, still waiting after 1000 cycles.
- rst_i asserted in ACCESS → all outputs 0 same cycle. A following read of 0x2001_9000 completes normally.
- Boundary addresses 0x2001_0FFF (idx 5), 0x2001_1000 (idx 6), 0x2001_A000 (miss) → correct select or error for each.
